// File: rtl/arm_it_pkg.sv
// Shared IT-block constants: opcode byte, APSR bit positions, checker error codes and condition encodings.
// Pure definitions; no logic, no timing, no flow control.
package arm_it_pkg;

    localparam logic [7:0] IT_OPCODE = 8'hBF;

    localparam int APSR_N = 4;
    localparam int APSR_Z = 3;
    localparam int APSR_C = 2;
    localparam int APSR_V = 1;
    localparam int APSR_Q = 0;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISMATCH = 2'b01;
    localparam logic [1:0] ERR_NEST     = 2'b10;
    localparam logic [1:0] ERR_BADCOND  = 2'b11;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

endpackage

// File: rtl/it_cond_eval.sv
// Thumb condition-code evaluator against APSR flags; purely combinational, zero latency, no flow control.
module it_cond_eval
    import arm_it_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [4:0] apsr,
    output logic       pass
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;
    logic w_base;
    logic w_unused_q;

    assign w_n        = apsr[APSR_N];
    assign w_z        = apsr[APSR_Z];
    assign w_c        = apsr[APSR_C];
    assign w_v        = apsr[APSR_V];
    assign w_unused_q = apsr[APSR_Q];

    always_comb begin
        w_base = 1'b1;
        case (cond[3:1])
            3'b000:  w_base = w_z;
            3'b001:  w_base = w_c;
            3'b010:  w_base = w_n;
            3'b011:  w_base = w_v;
            3'b100:  w_base = w_c & ~w_z;
            3'b101:  w_base = (w_n == w_v);
            3'b110:  w_base = (w_n == w_v) & ~w_z;
            default: w_base = 1'b1;
        endcase
    end

    // 4'hF shares AL's base and must not be inverted into "never".
    assign pass = (cond[0] && (cond != 4'hF)) ? ~w_base : w_base;

endmodule

// File: rtl/it_exec_checker.sv
// Shadow ITSTATE tracker comparing expected suppression with the core's hint_or_exc decision.
// exp_skip is combinational; all status updates land 1 cycle after the valid instruction; no backpressure.
module it_exec_checker
    import arm_it_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter bit CHECK_NEST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inst_valid,
    input  logic [31:0]      inst,
    input  logic [4:0]       apsr,
    input  logic             dut_skip,
    output logic             exp_skip,
    output logic             in_it,
    output logic [7:0]       itstate,
    output logic             err,
    output logic [1:0]       err_code,
    output logic             err_sticky,
    output logic [CNT_W-1:0] inst_cnt,
    output logic [CNT_W-1:0] skip_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [31:0]      first_inst,
    output logic [1:0]       first_code
);

    logic [7:0]       r_itstate;
    logic             r_err;
    logic [1:0]       r_err_code;
    logic             r_err_sticky;
    logic [CNT_W-1:0] r_inst_cnt;
    logic [CNT_W-1:0] r_skip_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic [31:0]      r_first_inst;
    logic [1:0]       r_first_code;

    logic       w_is_it;
    logic       w_in_it;
    logic       w_pass;
    logic       w_exp_skip;
    logic       w_nest;
    logic       w_advance;
    logic       w_load;
    logic [1:0] w_code;
    logic       w_err;
    logic       w_unused_lo;

    assign w_unused_lo = ^inst[15:0];

    // A zero mask is the IT-space hint NOP, not a block opener.
    assign w_is_it    = (inst[31:24] == IT_OPCODE) && (inst[19:16] != 4'h0);
    assign w_in_it    = (r_itstate[3:0] != 4'h0);

    it_cond_eval u_cond_eval (
        .cond (r_itstate[7:4]),
        .apsr (apsr),
        .pass (w_pass)
    );

    assign w_exp_skip = inst_valid & w_in_it & ~w_is_it & ~w_pass;
    assign w_nest     = w_in_it & w_is_it & CHECK_NEST;
    assign w_advance  = inst_valid & w_in_it & ~w_nest;
    assign w_load     = inst_valid & ~w_in_it & w_is_it;

    always_comb begin
        w_code = ERR_NONE;
        if (inst_valid) begin
            if (w_nest)
                w_code = ERR_NEST;
            else if (w_load && (inst[23:20] == 4'hF))
                w_code = ERR_BADCOND;
            else if (dut_skip != w_exp_skip)
                w_code = ERR_MISMATCH;
        end
    end

    assign w_err = (w_code != ERR_NONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_itstate    <= 8'h00;
            r_err        <= 1'b0;
            r_err_code   <= ERR_NONE;
            r_err_sticky <= 1'b0;
            r_inst_cnt   <= '0;
            r_skip_cnt   <= '0;
            r_err_cnt    <= '0;
            r_first_inst <= 32'h0;
            r_first_code <= ERR_NONE;
        end else begin
            r_err      <= w_err;
            r_err_code <= w_code;

            if (w_load)
                r_itstate <= inst[23:16];
            else if (w_advance)
                r_itstate <= (r_itstate[2:0] == 3'b000) ? 8'h00
                                                        : {r_itstate[7:5], r_itstate[3:0], 1'b0};

            // clr outranks a same-cycle error: that error is not counted or captured.
            if (clr) begin
                r_err_sticky <= 1'b0;
                r_inst_cnt   <= '0;
                r_skip_cnt   <= '0;
                r_err_cnt    <= '0;
                r_first_inst <= 32'h0;
                r_first_code <= ERR_NONE;
            end else begin
                if (inst_valid && (r_inst_cnt != '1))
                    r_inst_cnt <= r_inst_cnt + CNT_W'(1);
                if (w_exp_skip && (r_skip_cnt != '1))
                    r_skip_cnt <= r_skip_cnt + CNT_W'(1);
                if (w_err && (r_err_cnt != '1))
                    r_err_cnt <= r_err_cnt + CNT_W'(1);
                if (w_err)
                    r_err_sticky <= 1'b1;
                if (w_err && !r_err_sticky) begin
                    r_first_inst <= inst;
                    r_first_code <= w_code;
                end
            end
        end
    end

    assign exp_skip   = w_exp_skip;
    assign in_it      = w_in_it;
    assign itstate    = r_itstate;
    assign err        = r_err;
    assign err_code   = r_err_code;
    assign err_sticky = r_err_sticky;
    assign inst_cnt   = r_inst_cnt;
    assign skip_cnt   = r_skip_cnt;
    assign err_cnt    = r_err_cnt;
    assign first_inst = r_first_inst;
    assign first_code = r_first_code;

endmodule
